fetch_response: RTL and testbench



---
 rtl/fetch_response.sv | 115 +++++++++++
 tb/tb_fetch_response.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_response.sv
// Fetch response stage: filters killed/flushed I$ responses into a small FIFO, issues request credit and replays drops.
// Optional FETCH_RSP_BYPASS_EN presents a response on the head outputs in the same cycle when the FIFO is empty.
module fetch_response #(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned FETCH_WIDTH = 32,
    parameter int unsigned VLEN        = 39
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   kill_s2_i,
    input  logic                   icache_valid_i,
    input  logic [FETCH_WIDTH-1:0] icache_data_i,
    input  logic [VLEN-1:0]        icache_vaddr_i,
    input  logic                   icache_ex_i,
    output logic                   fetch_valid_o,
    output logic [FETCH_WIDTH-1:0] fetch_data_o,
    output logic [VLEN-1:0]        fetch_vaddr_o,
    output logic                   fetch_ex_o,
    input  logic                   fetch_ready_i,
    output logic                   instr_queue_ready_o,
    output logic                   replay_o,
    output logic [VLEN-1:0]        replay_addr_o
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = FETCH_WIDTH + VLEN + 1;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(DEPTH - 2);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               replay_q, replay_d;
    logic [VLEN-1:0]    replay_addr_q, replay_addr_d;

    logic               capture, empty, full, fifo_pop, push, drop;
    logic [ENTRY_W-1:0] rsp_entry, head_entry;

    assign capture   = icache_valid_i && !kill_s2_i && !flush_i;
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign fifo_pop  = !empty && fetch_ready_i;
    assign rsp_entry = {icache_ex_i, icache_vaddr_i, icache_data_i};

`ifdef FETCH_RSP_BYPASS_EN
    logic bypass;
    assign bypass        = empty && capture;
    assign fetch_valid_o = !empty || bypass;
    assign head_entry    = bypass ? rsp_entry : (empty ? '0 : mem_q[rptr_q]);
    // A bypassed response the consumer takes right away never touches storage.
    assign push          = capture && (!full || fifo_pop) && !(bypass && fetch_ready_i);
`else
    assign fetch_valid_o = !empty;
    assign head_entry    = empty ? '0 : mem_q[rptr_q];
    assign push          = capture && (!full || fifo_pop);
`endif

    assign drop = capture && full && !fifo_pop;
    assign {fetch_ex_o, fetch_vaddr_o, fetch_data_o} = head_entry;

    // One slot stays reserved for the request already in flight upstream.
    assign instr_queue_ready_o = (count_q <= CREDIT_MAX) && !flush_i;
    assign replay_o            = replay_q;
    assign replay_addr_o       = replay_addr_q;

    always_comb begin
        rptr_d        = rptr_q;
        wptr_d        = wptr_q;
        count_d       = count_q;
        replay_d      = drop;
        replay_addr_d = drop ? icache_vaddr_i : replay_addr_q;
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push, fifo_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q        <= '0;
            wptr_q        <= '0;
            count_q       <= '0;
            replay_q      <= 1'b0;
            replay_addr_q <= '0;
        end else begin
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            count_q       <= count_d;
            replay_q      <= replay_d;
            replay_addr_q <= replay_addr_d;
        end
    end

    // Entry storage is unreset; head outputs are masked by the count instead.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= rsp_entry;
        end
    end

endmodule

// File: tb/tb_fetch_response.sv
// Directed self-checking bench for fetch_response (DEPTH=2); expectations follow the bypass macro when it is set.
module tb_fetch_response;

    localparam int FW = 32;
    localparam int VL = 39;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          kill_s2_i = 1'b0;
    logic          icache_valid_i = 1'b0;
    logic [FW-1:0] icache_data_i = '0;
    logic [VL-1:0] icache_vaddr_i = '0;
    logic          icache_ex_i = 1'b0;
    logic          fetch_valid_o;
    logic [FW-1:0] fetch_data_o;
    logic [VL-1:0] fetch_vaddr_o;
    logic          fetch_ex_o;
    logic          fetch_ready_i = 1'b0;
    logic          instr_queue_ready_o;
    logic          replay_o;
    logic [VL-1:0] replay_addr_o;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_response #(.DEPTH(2), .FETCH_WIDTH(FW), .VLEN(VL)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .flush_i            (flush_i),
        .kill_s2_i          (kill_s2_i),
        .icache_valid_i     (icache_valid_i),
        .icache_data_i      (icache_data_i),
        .icache_vaddr_i     (icache_vaddr_i),
        .icache_ex_i        (icache_ex_i),
        .fetch_valid_o      (fetch_valid_o),
        .fetch_data_o       (fetch_data_o),
        .fetch_vaddr_o      (fetch_vaddr_o),
        .fetch_ex_o         (fetch_ex_o),
        .fetch_ready_i      (fetch_ready_i),
        .instr_queue_ready_o(instr_queue_ready_o),
        .replay_o           (replay_o),
        .replay_addr_o      (replay_addr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic v, input logic k, input logic f, input logic r,
                         input logic [VL-1:0] a, input logic [FW-1:0] d, input logic e);
        @(negedge clk_i);
        icache_valid_i = v;
        kill_s2_i      = k;
        flush_i        = f;
        fetch_ready_i  = r;
        icache_vaddr_i = a;
        icache_data_i  = d;
        icache_ex_i    = e;
    endtask

    task automatic after_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", fetch_valid_o); end
        n_cmp++; if (fetch_data_o !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", fetch_data_o); end
        n_cmp++; if (fetch_vaddr_o !== '0) begin n_bad++; $display("FAIL reset_vaddr: got %h want 0", fetch_vaddr_o); end
        n_cmp++; if (fetch_ex_o !== 1'b0) begin n_bad++; $display("FAIL reset_ex: got %b want 0", fetch_ex_o); end
        n_cmp++; if (instr_queue_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_credit: got %b want 1", instr_queue_ready_o); end
        n_cmp++; if (replay_o !== 1'b0) begin n_bad++; $display("FAIL reset_replay: got %b want 0", replay_o); end
        n_cmp++; if (replay_addr_o !== '0) begin n_bad++; $display("FAIL reset_replay_addr: got %h want 0", replay_addr_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_single();
        drive(1, 0, 0, 1, 'h1000, 32'hDEADBEEF, 0);
        #1;
`ifdef FETCH_RSP_BYPASS_EN
        n_cmp++; if (fetch_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_byp_valid: got %b want 1", fetch_valid_o); end
        n_cmp++; if (fetch_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_byp_data: got %h want deadbeef", fetch_data_o); end
        n_cmp++; if (fetch_vaddr_o !== 39'h1000) begin n_bad++; $display("FAIL single_byp_vaddr: got %h want 1000", fetch_vaddr_o); end
        after_edge();
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_byp_consumed: got %b want 0", fetch_valid_o); end
`else
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_same_cycle: got %b want 0", fetch_valid_o); end
        after_edge();
        n_cmp++; if (fetch_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", fetch_valid_o); end
        n_cmp++; if (fetch_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_data: got %h want deadbeef", fetch_data_o); end
        n_cmp++; if (fetch_vaddr_o !== 39'h1000) begin n_bad++; $display("FAIL single_vaddr: got %h want 1000", fetch_vaddr_o); end
`endif
        drive(0, 0, 0, 1, '0, '0, 0);
        after_edge();
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_drained: got %b want 0", fetch_valid_o); end
        n_cmp++; if (instr_queue_ready_o !== 1'b1) begin n_bad++; $display("FAIL single_credit: got %b want 1", instr_queue_ready_o); end
    endtask

    task automatic test_fill_credit();
        drive(1, 0, 0, 0, 'h1000, 32'hA, 0);
        after_edge();
        n_cmp++; if (fetch_valid_o !== 1'b1) begin n_bad++; $display("FAIL fill_valid: got %b want 1", fetch_valid_o); end
        n_cmp++; if (fetch_vaddr_o !== 39'h1000) begin n_bad++; $display("FAIL fill_head1: got %h want 1000", fetch_vaddr_o); end
        n_cmp++; if (instr_queue_ready_o !== 1'b0) begin n_bad++; $display("FAIL fill_credit: got %b want 0", instr_queue_ready_o); end
        drive(1, 0, 0, 0, 'h1004, 32'hB, 0);
        after_edge();
        n_cmp++; if (replay_o !== 1'b0) begin n_bad++; $display("FAIL fill_no_replay: got %b want 0", replay_o); end
        n_cmp++; if (fetch_vaddr_o !== 39'h1000) begin n_bad++; $display("FAIL fill_head2: got %h want 1000", fetch_vaddr_o); end
        drive(1, 0, 0, 0, 'h1008, 32'hC, 0);
        after_edge();
        n_cmp++; if (replay_o !== 1'b1) begin n_bad++; $display("FAIL drop_replay: got %b want 1", replay_o); end
        n_cmp++; if (replay_addr_o !== 39'h1008) begin n_bad++; $display("FAIL drop_replay_addr: got %h want 1008", replay_addr_o); end
        drive(0, 0, 0, 0, '0, '0, 0);
        after_edge();
        n_cmp++; if (replay_o !== 1'b0) begin n_bad++; $display("FAIL drop_replay_pulse: got %b want 0", replay_o); end
        n_cmp++; if (fetch_vaddr_o !== 39'h1000) begin n_bad++; $display("FAIL drop_head_kept: got %h want 1000", fetch_vaddr_o); end
    endtask

    task automatic test_full_pop_push();
        drive(1, 0, 0, 1, 'h2000, 32'hD, 0);
        after_edge();
        n_cmp++; if (replay_o !== 1'b0) begin n_bad++; $display("FAIL fpp_no_replay: got %b want 0", replay_o); end
        n_cmp++; if (fetch_vaddr_o !== 39'h1004) begin n_bad++; $display("FAIL fpp_head: got %h want 1004", fetch_vaddr_o); end
        n_cmp++; if (fetch_data_o !== 32'hB) begin n_bad++; $display("FAIL fpp_data: got %h want b", fetch_data_o); end
        drive(0, 0, 0, 0, '0, '0, 0);
        after_edge();
        n_cmp++; if (fetch_vaddr_o !== 39'h1004) begin n_bad++; $display("FAIL fpp_hold: got %h want 1004", fetch_vaddr_o); end
        drive(0, 0, 0, 1, '0, '0, 0);
        after_edge();
        n_cmp++; if (fetch_vaddr_o !== 39'h2000) begin n_bad++; $display("FAIL fpp_second: got %h want 2000", fetch_vaddr_o); end
        n_cmp++; if (fetch_data_o !== 32'hD) begin n_bad++; $display("FAIL fpp_second_data: got %h want d", fetch_data_o); end
        after_edge();
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL fpp_empty: got %b want 0", fetch_valid_o); end
        n_cmp++; if (instr_queue_ready_o !== 1'b1) begin n_bad++; $display("FAIL fpp_credit: got %b want 1", instr_queue_ready_o); end
    endtask

    task automatic test_kill();
        drive(1, 1, 0, 0, 'h3000, 32'h3, 0);
        #1;
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL kill_same_cycle: got %b want 0", fetch_valid_o); end
        after_edge();
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL kill_valid: got %b want 0", fetch_valid_o); end
        n_cmp++; if (replay_o !== 1'b0) begin n_bad++; $display("FAIL kill_replay: got %b want 0", replay_o); end
        drive(0, 0, 0, 0, '0, '0, 0);
        after_edge();
        n_cmp++; if (replay_o !== 1'b0) begin n_bad++; $display("FAIL kill_replay_late: got %b want 0", replay_o); end
    endtask

    task automatic test_empty_ready();
        drive(0, 0, 0, 1, '0, '0, 0);
        repeat (3) after_edge();
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL empty_ready_valid: got %b want 0", fetch_valid_o); end
        drive(1, 0, 0, 0, 'h3100, 32'h31, 0);
        after_edge();
        n_cmp++; if (fetch_vaddr_o !== 39'h3100) begin n_bad++; $display("FAIL empty_ready_head: got %h want 3100", fetch_vaddr_o); end
        n_cmp++; if (instr_queue_ready_o !== 1'b0) begin n_bad++; $display("FAIL empty_ready_credit: got %b want 0", instr_queue_ready_o); end
        drive(0, 0, 0, 1, '0, '0, 0);
        after_edge();
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL empty_ready_drain: got %b want 0", fetch_valid_o); end
    endtask

    task automatic test_flush();
        drive(1, 0, 0, 0, 'h4000, 32'h40, 0);
        drive(1, 0, 0, 0, 'h4004, 32'h44, 0);
        drive(1, 0, 1, 0, 'h4008, 32'h48, 0);
        #1;
        n_cmp++; if (instr_queue_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_credit_during: got %b want 0", instr_queue_ready_o); end
        after_edge();
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", fetch_valid_o); end
        n_cmp++; if (replay_o !== 1'b0) begin n_bad++; $display("FAIL flush_replay: got %b want 0", replay_o); end
        drive(0, 0, 0, 0, '0, '0, 0);
        #1;
        n_cmp++; if (instr_queue_ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_credit_after: got %b want 1", instr_queue_ready_o); end
        after_edge();
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_stays_empty: got %b want 0", fetch_valid_o); end
    endtask

    task automatic test_exception_reset();
        drive(1, 0, 0, 0, 'h5000, 32'h12345678, 1);
        after_edge();
        n_cmp++; if (fetch_ex_o !== 1'b1) begin n_bad++; $display("FAIL ex_flag: got %b want 1", fetch_ex_o); end
        n_cmp++; if (fetch_data_o !== 32'h12345678) begin n_bad++; $display("FAIL ex_data: got %h want 12345678", fetch_data_o); end
        drive(1, 0, 0, 0, 'h5004, 32'h55, 0);
        after_edge();
        n_cmp++; if (fetch_ex_o !== 1'b1) begin n_bad++; $display("FAIL ex_head_kept: got %b want 1", fetch_ex_o); end
        drive(1, 0, 0, 0, 'h5008, 32'h58, 0);
        after_edge();
        n_cmp++; if (replay_o !== 1'b1) begin n_bad++; $display("FAIL ex_replay: got %b want 1", replay_o); end
        icache_valid_i = 1'b0;
        #1;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", fetch_valid_o); end
        n_cmp++; if (fetch_data_o !== '0) begin n_bad++; $display("FAIL rst_mid_data: got %h want 0", fetch_data_o); end
        n_cmp++; if (fetch_vaddr_o !== '0) begin n_bad++; $display("FAIL rst_mid_vaddr: got %h want 0", fetch_vaddr_o); end
        n_cmp++; if (fetch_ex_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ex: got %b want 0", fetch_ex_o); end
        n_cmp++; if (instr_queue_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_mid_credit: got %b want 1", instr_queue_ready_o); end
        n_cmp++; if (replay_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_replay: got %b want 0", replay_o); end
        n_cmp++; if (replay_addr_o !== '0) begin n_bad++; $display("FAIL rst_mid_replay_addr: got %h want 0", replay_addr_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(0, 0, 0, 0, '0, '0, 0);
        after_edge();
        n_cmp++; if (fetch_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_after_valid: got %b want 0", fetch_valid_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_credit();
        test_full_pop_push();
        test_kill();
        test_empty_ready();
        test_flush();
        test_exception_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
